// File: rtl/id_decode_stage.sv
// ----------------------------------------------------------------------------
// id_decode_stage
//   Registered RV32I decode stage. It turns each instruction from the IF/ID
//   register into a control bundle for the execute stage. Features:
//   valid/ready handshake, load-use bubble insertion, flush, illegal
//   instruction flagging, optional M-extension multiply decode and a
//   saturating load-use bubble counter.
//
// Parameters
//   XLEN      PC width
//   ENABLE_M  1: decode MUL/MULH/MULHSU/MULHU, 0: flag them illegal
//   CNT_W     width of the stall counter
//
// Ports
//   i_clk, i_rst_n        clock (rising edge), asynchronous active-low reset
//   i_valid/o_ready       upstream handshake (instruction in)
//   i_instr, i_pc         instruction word and its PC
//   i_flush               kills the held bundle and the incoming instruction
//   o_valid/i_ready       downstream handshake (bundle out)
//   o_pc, o_rs1/2, o_rd   registered PC and register fields
//   o_alu_op              0 add,1 sub,2 sll,3 slt,4 sltu,5 xor,6 srl,7 sra,
//                         8 or,9 and,A mul,B mulh,C mulhsu,D mulhu
//   o_op1_sel             0 rs1, 1 pc, 2 zero
//   o_op2_sel             0 rs2, 1 imm
//   o_wb_sel              0 alu, 1 mem, 2 pc+4
//   o_rd_wren .. o_is_ctrl  control enables/flags
//   o_illegal             bundle holds an undecodable instruction
//   o_stall_cnt           saturating count of inserted load-use bubbles
// ----------------------------------------------------------------------------
module id_decode_stage #(
  parameter int XLEN     = 32,
  parameter int ENABLE_M = 0,
  parameter int CNT_W    = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [31:0]      i_instr,
  input  logic [XLEN-1:0]  i_pc,
  input  logic             i_flush,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [XLEN-1:0]  o_pc,
  output logic [4:0]       o_rs1,
  output logic [4:0]       o_rs2,
  output logic [4:0]       o_rd,
  output logic [3:0]       o_alu_op,
  output logic [1:0]       o_op1_sel,
  output logic             o_op2_sel,
  output logic [1:0]       o_wb_sel,
  output logic             o_rd_wren,
  output logic             o_mem_rden,
  output logic             o_mem_wren,
  output logic             o_branch,
  output logic             o_jump,
  output logic             o_br_unsign,
  output logic             o_is_ctrl,
  output logic             o_illegal,
  output logic [CNT_W-1:0] o_stall_cnt
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_SRA = 4'h7;
  localparam logic [3:0] ALU_MUL = 4'hA;

  // Instruction fields
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rs1_field;
  logic [4:0] rs2_field;
  logic [4:0] rd_field;

  assign opcode    = i_instr[6:0];
  assign rd_field  = i_instr[11:7];
  assign funct3    = i_instr[14:12];
  assign rs1_field = i_instr[19:15];
  assign rs2_field = i_instr[24:20];
  assign funct7    = i_instr[31:25];

  // Decoded (next) bundle
  logic [3:0] alu_op_next;
  logic [1:0] op1_sel_next;
  logic       op2_sel_next;
  logic [1:0] wb_sel_next;
  logic       rd_wren_next;
  logic       mem_rden_next;
  logic       mem_wren_next;
  logic       branch_next;
  logic       jump_next;
  logic       br_unsign_next;
  logic       is_ctrl_next;
  logic       illegal_next;
  logic       use_rs1;
  logic       use_rs2;

  // Registered bundle
  logic             valid_reg;
  logic [XLEN-1:0]  pc_reg;
  logic [4:0]       rs1_reg;
  logic [4:0]       rs2_reg;
  logic [4:0]       rd_reg;
  logic [3:0]       alu_op_reg;
  logic [1:0]       op1_sel_reg;
  logic             op2_sel_reg;
  logic [1:0]       wb_sel_reg;
  logic             rd_wren_reg;
  logic             mem_rden_reg;
  logic             mem_wren_reg;
  logic             branch_reg;
  logic             jump_reg;
  logic             br_unsign_reg;
  logic             is_ctrl_reg;
  logic             illegal_reg;
  logic [CNT_W-1:0] stall_cnt_reg;

  logic hazard;
  logic src_match;

  // funct3 -> ALU op for the shared R/I encodings (funct7 = 0 flavour)
  function automatic logic [3:0] base_alu(input logic [2:0] f3);
    case (f3)
      3'b000:  base_alu = 4'h0;  // add
      3'b001:  base_alu = 4'h2;  // sll
      3'b010:  base_alu = 4'h3;  // slt
      3'b011:  base_alu = 4'h4;  // sltu
      3'b100:  base_alu = 4'h5;  // xor
      3'b101:  base_alu = 4'h6;  // srl
      3'b110:  base_alu = 4'h8;  // or
      default: base_alu = 4'h9;  // and
    endcase
  endfunction

  always_comb begin
    alu_op_next    = ALU_ADD;
    op1_sel_next   = 2'd0;
    op2_sel_next   = 1'b0;
    wb_sel_next    = 2'd0;
    rd_wren_next   = 1'b0;
    mem_rden_next  = 1'b0;
    mem_wren_next  = 1'b0;
    branch_next    = 1'b0;
    jump_next      = 1'b0;
    br_unsign_next = 1'b0;
    is_ctrl_next   = 1'b0;
    illegal_next   = 1'b0;
    use_rs1        = 1'b0;
    use_rs2        = 1'b0;

    case (opcode)
      OP_R: begin
        use_rs1      = 1'b1;
        use_rs2      = 1'b1;
        rd_wren_next = 1'b1;
        case (funct7)
          7'b0000000: alu_op_next = base_alu(funct3);
          7'b0100000: begin
            if (funct3 == 3'b000)      alu_op_next = ALU_SUB;
            else if (funct3 == 3'b101) alu_op_next = ALU_SRA;
            else                       illegal_next = 1'b1;
          end
          7'b0000001: begin
            // Only the four multiplies; divide/remainder are never decoded
            if ((ENABLE_M != 0) && !funct3[2])
              alu_op_next = ALU_MUL + {2'b00, funct3[1:0]};
            else
              illegal_next = 1'b1;
          end
          default: illegal_next = 1'b1;
        endcase
      end
      OP_I: begin
        use_rs1      = 1'b1;
        op2_sel_next = 1'b1;
        rd_wren_next = 1'b1;
        // inst[30] is an immediate bit for addi etc.; it only means sra for srai
        if (funct3 == 3'b101 && i_instr[30]) alu_op_next = ALU_SRA;
        else                                 alu_op_next = base_alu(funct3);
      end
      OP_LOAD: begin
        use_rs1       = 1'b1;
        op2_sel_next  = 1'b1;
        wb_sel_next   = 2'd1;
        mem_rden_next = 1'b1;
        rd_wren_next  = 1'b1;
      end
      OP_S: begin
        use_rs1       = 1'b1;
        use_rs2       = 1'b1;
        op2_sel_next  = 1'b1;
        mem_wren_next = 1'b1;
      end
      OP_B: begin
        use_rs1        = 1'b1;
        use_rs2        = 1'b1;
        op1_sel_next   = 2'd1;
        op2_sel_next   = 1'b1;
        branch_next    = 1'b1;
        is_ctrl_next   = 1'b1;
        br_unsign_next = (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      OP_JAL: begin
        op1_sel_next = 2'd1;
        op2_sel_next = 1'b1;
        wb_sel_next  = 2'd2;
        jump_next    = 1'b1;
        is_ctrl_next = 1'b1;
        rd_wren_next = 1'b1;
      end
      OP_JALR: begin
        use_rs1      = 1'b1;
        op2_sel_next = 1'b1;
        wb_sel_next  = 2'd2;
        jump_next    = 1'b1;
        is_ctrl_next = 1'b1;
        rd_wren_next = 1'b1;
      end
      OP_LUI: begin
        op1_sel_next = 2'd2;
        op2_sel_next = 1'b1;
        rd_wren_next = 1'b1;
      end
      OP_AUIPC: begin
        op1_sel_next = 2'd1;
        op2_sel_next = 1'b1;
        rd_wren_next = 1'b1;
      end
      default: illegal_next = 1'b1;
    endcase

    // An undecodable instruction must never cause side effects downstream
    if (illegal_next) begin
      rd_wren_next  = 1'b0;
      mem_rden_next = 1'b0;
      mem_wren_next = 1'b0;
      branch_next   = 1'b0;
      jump_next     = 1'b0;
    end
  end

  // Load in the bundle whose result the incoming instruction needs.
  // x0 is never a real dependency.
  assign src_match = (use_rs1 && (rs1_field == rd_reg)) ||
                     (use_rs2 && (rs2_field == rd_reg));
  assign hazard    = valid_reg && mem_rden_reg && (rd_reg != 5'd0) &&
                     src_match && i_valid;
  assign o_ready   = !i_flush && !hazard && (!valid_reg || i_ready);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_reg     <= 1'b0;
      pc_reg        <= '0;
      rs1_reg       <= '0;
      rs2_reg       <= '0;
      rd_reg        <= '0;
      alu_op_reg    <= '0;
      op1_sel_reg   <= '0;
      op2_sel_reg   <= 1'b0;
      wb_sel_reg    <= '0;
      rd_wren_reg   <= 1'b0;
      mem_rden_reg  <= 1'b0;
      mem_wren_reg  <= 1'b0;
      branch_reg    <= 1'b0;
      jump_reg      <= 1'b0;
      br_unsign_reg <= 1'b0;
      is_ctrl_reg   <= 1'b0;
      illegal_reg   <= 1'b0;
      stall_cnt_reg <= '0;
    end else if (i_flush) begin
      valid_reg <= 1'b0;
    end else if (i_valid && o_ready) begin
      valid_reg     <= 1'b1;
      pc_reg        <= i_pc;
      rs1_reg       <= rs1_field;
      rs2_reg       <= rs2_field;
      rd_reg        <= rd_field;
      alu_op_reg    <= alu_op_next;
      op1_sel_reg   <= op1_sel_next;
      op2_sel_reg   <= op2_sel_next;
      wb_sel_reg    <= wb_sel_next;
      rd_wren_reg   <= rd_wren_next;
      mem_rden_reg  <= mem_rden_next;
      mem_wren_reg  <= mem_wren_next;
      branch_reg    <= branch_next;
      jump_reg      <= jump_next;
      br_unsign_reg <= br_unsign_next;
      is_ctrl_reg   <= is_ctrl_next;
      illegal_reg   <= illegal_next;
    end else if (hazard && i_ready) begin
      // The load leaves this cycle; a bubble follows it so the dependent
      // instruction sees the load result one cycle later.
      valid_reg <= 1'b0;
      if (stall_cnt_reg != {CNT_W{1'b1}})
        stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
    end else if (!valid_reg || i_ready) begin
      valid_reg <= 1'b0;
    end
  end

  assign o_valid     = valid_reg;
  assign o_pc        = pc_reg;
  assign o_rs1       = rs1_reg;
  assign o_rs2       = rs2_reg;
  assign o_rd        = rd_reg;
  assign o_alu_op    = alu_op_reg;
  assign o_op1_sel   = op1_sel_reg;
  assign o_op2_sel   = op2_sel_reg;
  assign o_wb_sel    = wb_sel_reg;
  assign o_rd_wren   = rd_wren_reg;
  assign o_mem_rden  = mem_rden_reg;
  assign o_mem_wren  = mem_wren_reg;
  assign o_branch    = branch_reg;
  assign o_jump      = jump_reg;
  assign o_br_unsign = br_unsign_reg;
  assign o_is_ctrl   = is_ctrl_reg;
  assign o_illegal   = illegal_reg;
  assign o_stall_cnt = stall_cnt_reg;

endmodule

// File: doc/id_decode_stage.md
# id_decode_stage

Registered, parametrised decode stage for the pipelined RV32I core. It sits between the IF/ID register and the execute stage, and turns each 32-bit instruction into a registered control bundle. It adds a valid/ready handshake, load-use bubble insertion, flush, illegal-instruction flagging, optional M-extension multiply decode and a saturating stall counter.

## Interface
- `XLEN`, 32: PC width.
- `ENABLE_M`, 0: 1 enables MUL/MULH/MULHSU/MULHU decode; 0 flags them illegal.
- `CNT_W`, 16: stall-counter width.
- `i_clk` input 1: clock, rising edge.
- `i_rst_n` input 1: asynchronous, active-low reset.
- `i_valid` input 1: upstream instruction valid.
- `o_ready` output 1: stage accepts the instruction this cycle.
- `i_instr` input 32: instruction.
- `i_pc` input XLEN: instruction PC.
- `i_flush` input 1: synchronous kill of held and incoming instructions.
- `o_valid` output 1: control bundle valid.
- `i_ready` input 1: execute stage accepts the bundle.
- `o_pc` output XLEN; `o_rs1`, `o_rs2`, `o_rd` output 5 each: registered fields.
- `o_alu_op` output 4: 0 add, 1 sub, 2 sll, 3 slt, 4 sltu, 5 xor, 6 srl, 7 sra, 8 or, 9 and, A mul, B mulh, C mulhsu, D mulhu.
- `o_op1_sel` output 2: 0 rs1, 1 pc, 2 zero.
- `o_op2_sel` output 1: 0 rs2, 1 imm.
- `o_wb_sel` output 2: 0 alu, 1 mem, 2 pc+4.
- `o_rd_wren`, `o_mem_rden`, `o_mem_wren`, `o_branch`, `o_jump`, `o_br_unsign`, `o_is_ctrl` output 1 each.
- `o_illegal` output 1: bundle holds an undecodable instruction.
- `o_stall_cnt` output CNT_W: count of load-use bubbles, saturating.

## Operation
- Opcode map:
  - R 0110011: rs1/rs2, alu, wren.
  - I 0010011: rs1/imm, alu, wren.
  - Load 0000011: rs1/imm, add, wb mem, rden, wren.
  - S 0100011: rs1/imm, add, mem_wren.
  - B 1100011: pc/imm, add, branch, is_ctrl.
  - JAL 1101111: pc/imm, add, wb pc+4, jump, is_ctrl, wren.
  - JALR 1100111: rs1/imm, add, wb pc+4, jump, is_ctrl, wren.
  - LUI 0110111: zero/imm, add, wren.
  - AUIPC 0010111: pc/imm, add, wren.
- R-type funct7 rules:
  - funct7=0000000 uses funct3 for ops 0,2–6,8,9.
  - funct7=0100000 is valid only with funct3 000 (sub) or 101 (sra).
  - funct7=0000001 with funct3 000–011 maps to A–D only when `ENABLE_M`=1.
  - Any other combination is illegal.
- I-type: `inst[30]` selects sra only when funct3=101. addi never decodes as sub.
- `o_br_unsign`=1 only for bltu/bgeu; otherwise 0.
- Illegal handling: unknown opcode or funct combination sets `o_illegal`=1 and forces every enable (rd_wren, mem_rden, mem_wren, branch, jump) to 0.
- Source-use rule: R, S and B types use both rs1 and rs2. I, load and JALR use rs1 only. LUI, AUIPC and JAL use neither.
- Load-use hazard: `hazard` = `o_valid` & `o_mem_rden` & `o_rd`≠0 & (`o_rd` equals a used source of `i_instr`) & `i_valid`.
- Handshake: `o_ready` = ~`i_flush` & ~`hazard` & (~`o_valid` | `i_ready`).
- Register update, in priority order:
  1. `i_flush`: `o_valid`←0; the incoming instruction is dropped.
  2. `i_valid` & `o_ready`: load the new bundle and set `o_valid`←1.
  3. `hazard` & `i_ready`: `o_valid`←0, which inserts the bubble; `o_stall_cnt` increments, saturating at all-ones.
  4. ~`o_valid` | `i_ready`: `o_valid`←0.
  5. Otherwise hold all outputs.
- Bundle fields may retain stale values while `o_valid`=0. Consumers qualify them with `o_valid`.

## Timing
- Latency is 1 cycle: an instruction accepted at edge N appears on the outputs after edge N.
- Reset (`i_rst_n`=0, asynchronous) drives every output register, including `o_stall_cnt`, to 0. Consequently `o_valid`=0 and `o_ready`=1 at the first edge after release.
- Reset asserted mid-stall: the bubble and the held bundle are discarded; the counter clears.
- Backpressure: while `o_valid`=1 and `i_ready`=0, outputs are stable and `o_ready`=0.
- Hazard with `i_ready`=0: the stage holds; no bubble is inserted and no count is taken until `i_ready`=1.
- Exactly one bubble is inserted per load-use pair.
- Full-throughput: 1 instruction/cycle when `i_valid`=`i_ready`=1 and no hazard.
- Simultaneous flush and hazard: flush wins and the counter does not increment.

## Test plan
- Reset, then `add x3,x1,x2` (0x002081B3) → next cycle `o_valid`=1, alu_op 0, rd 3, rd_wren 1, op2_sel 0.
- `lw x5,0(x1)` followed by `add x6,x5,x2` with `i_ready`=1 → cycle 1 shows load; cycle 2 `o_valid`=0 with `o_stall_cnt`=1; cycle 3 shows add.
- `lw x0,…` followed by a use of x0 → no bubble; `o_stall_cnt` stays 0.
- `mul x1,x2,x3` (0x023100B3) → alu_op A with `ENABLE_M`=1; with `ENABLE_M`=0: `o_illegal`=1 and rd_wren 0.
- `bgeu` → br_unsign 1, branch 1, is_ctrl 1, op1_sel 1. Then `i_ready`=0 for 3 cycles → outputs stable and `o_ready`=0.
- `i_flush`=1 while `o_valid`=1 and `i_valid`=1 → next cycle `o_valid`=0, the incoming instruction is never issued, and the counter is unchanged. Also check saturation with `CNT_W`=2: 4 bubbles leave the count at 3.
